// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit processor: opcodes, instruction field
// positions and the fetch FSM state encoding.
package isa_pkg;

    localparam logic [3:0] NOP   = 4'd0;
    localparam logic [3:0] ADD   = 4'd1;
    localparam logic [3:0] SUB   = 4'd2;
    localparam logic [3:0] AND   = 4'd3;
    localparam logic [3:0] OR    = 4'd4;
    localparam logic [3:0] NOT   = 4'd5;
    localparam logic [3:0] XOR   = 4'd6;
    localparam logic [3:0] CLEAR = 4'd7;
    localparam logic [3:0] MOVE  = 4'd8;
    localparam logic [3:0] LOAD  = 4'd9;
    localparam logic [3:0] STORE = 4'd10;
    localparam logic [3:0] PRINT = 4'd11;
    localparam logic [3:0] JMP   = 4'd12;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int REG_HI = 11;
    localparam int REG_LO = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE
    } fetch_state_t;

    // Codes 13-15 are deliberately not JMP; only the exact JMP code redirects.
    function automatic logic is_jmp(input logic [15:0] instr);
        return instr[OPC_HI:OPC_LO] == JMP;
    endfunction

endpackage

// File: rtl/prog_counter.sv
// Program counter register: load has priority over increment, wraps modulo 2^ADDR_W.
module prog_counter #(
    parameter int ADDR_W     = 8,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= ADDR_W'(START_ADDR);
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the ROM address from the PC, captures the word
// into IR, resolves JMP locally and issues everything else over valid/ready.
module fetch_unit
    import isa_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int INSTR_W    = 16,
    parameter int START_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic [ADDR_W-1:0]  addr_p,
    input  logic [INSTR_W-1:0] in_prom,
    output logic [INSTR_W-1:0] instr_out,
    output logic [3:0]         opcode,
    output logic [3:0]         reg_sel,
    output logic [7:0]         imm,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc
);

    fetch_state_t       state;
    fetch_state_t       next_state;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  jmp_target;
    logic               pc_load;
    logic               pc_inc;
    logic               ir_load;

    assign jmp_target = ADDR_W'(in_prom[IMM_HI:IMM_LO]);

    prog_counter #(
        .ADDR_W    (ADDR_W),
        .START_ADDR(START_ADDR)
    ) u_prog_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (pc_load),
        .inc     (pc_inc),
        .load_val(jmp_target),
        .pc      (pc_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= '0;
        end else if (ir_load) begin
            ir <= in_prom;
        end
    end

    // run is only honoured in IDLE and at handshake completion, never mid-fetch.
    always_comb begin
        next_state = state;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        ir_load    = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                next_state = DECODE;
            end
            DECODE: begin
                ir_load = 1'b1;
                if (is_jmp(in_prom[15:0])) begin
                    pc_load    = 1'b1;
                    next_state = FETCH;
                end else begin
                    pc_inc     = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    next_state = run ? FETCH : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign instr_valid = (state == ISSUE);
    assign instr_out   = ir;
    assign opcode      = ir[OPC_HI:OPC_LO];
    assign reg_sel     = ir[REG_HI:REG_LO];
    assign imm         = ir[IMM_HI:IMM_LO];
    assign addr_p      = pc_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a one-cycle registered-address ROM model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [7:0]  addr_p;
    logic [15:0] in_prom;
    logic [15:0] instr_out;
    logic [3:0]  opcode;
    logic [3:0]  reg_sel;
    logic [7:0]  imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  pc;

    logic [15:0] rom [0:255];
    int          checks;
    int          failures;

    fetch_unit #(
        .ADDR_W    (8),
        .INSTR_W   (16),
        .START_ADDR(0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .addr_p     (addr_p),
        .in_prom    (in_prom),
        .instr_out  (instr_out),
        .opcode     (opcode),
        .reg_sel    (reg_sel),
        .imm        (imm),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) in_prom <= rom[addr_p];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // n-1 edges with nothing issued, then the issue edge with the expected word.
    task automatic waitIssue(input int n, input logic [15:0] exp_instr, input logic [7:0] exp_pc);
        for (int i = 1; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("valid_low", 32'(instr_valid), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("valid_high", 32'(instr_valid), 32'd1);
        checkOutput("instr_out", 32'(instr_out), 32'(exp_instr));
        checkOutput("opcode", 32'(opcode), 32'(exp_instr[15:12]));
        checkOutput("reg_sel", 32'(reg_sel), 32'(exp_instr[11:8]));
        checkOutput("imm", 32'(imm), 32'(exp_instr[7:0]));
        checkOutput("pc", 32'(pc), 32'(exp_pc));
        checkOutput("addr_p", 32'(addr_p), 32'(exp_pc));
    endtask

    task automatic applyStimulus();
        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
        rom[0]   = 16'h8004;
        rom[1]   = 16'h8205;
        rom[2]   = 16'h1200;
        rom[3]   = 16'hB500;
        rom[4]   = 16'h2100;
        rom[5]   = 16'hC00A;
        rom[10]  = 16'h1200;
        rom[11]  = 16'h7300;
        rom[12]  = 16'hC0FF;
        rom[255] = 16'h4300;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulseReset();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_instr", 32'(instr_out), 32'd0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        run         = 1'b0;
        instr_ready = 1'b1;
        applyStimulus();

        #3;
        checkOutput("reset_addr_p", 32'(addr_p), 32'd0);
        checkOutput("reset_pc", 32'(pc), 32'd0);
        checkOutput("reset_instr", 32'(instr_out), 32'd0);
        checkOutput("reset_opcode", 32'(opcode), 32'd0);
        checkOutput("reset_imm", 32'(imm), 32'd0);
        checkOutput("reset_valid", 32'(instr_valid), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle_hold_pc", 32'(pc), 32'd0);
        checkOutput("idle_valid", 32'(instr_valid), 32'd0);

        run = 1'b1;
        waitIssue(3, 16'h8004, 8'd1);
        waitIssue(3, 16'h8205, 8'd2);
        waitIssue(3, 16'h1200, 8'd3);
        waitIssue(3, 16'hB500, 8'd4);
        waitIssue(3, 16'h2100, 8'd5);
        // JMP at 5 costs two extra cycles and is never issued.
        waitIssue(5, 16'h1200, 8'd11);

        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("stall_valid", 32'(instr_valid), 32'd1);
            checkOutput("stall_instr", 32'(instr_out), 32'h1200);
            checkOutput("stall_pc", 32'(pc), 32'd11);
        end
        instr_ready = 1'b1;
        waitIssue(3, 16'h7300, 8'd12);

        // JMP to 255, then PC wraps to 0 after the non-JMP there.
        waitIssue(5, 16'h4300, 8'd0);
        waitIssue(3, 16'h8004, 8'd1);

        @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        checkOutput("rundrop_fetch_valid", 32'(instr_valid), 32'd0);
        waitIssue(2, 16'h8205, 8'd2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("park_valid", 32'(instr_valid), 32'd0);
            checkOutput("park_addr_p", 32'(addr_p), 32'd2);
        end
        run = 1'b1;
        waitIssue(3, 16'h1200, 8'd3);

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        pulseReset();
        waitIssue(3, 16'h8004, 8'd1);

        pulseReset();
        waitIssue(3, 16'h8004, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
